// File: rtl/rs_dsp_pkg.sv
// Shared constants and helpers for the parametrised multiply-accumulate slice.
package rs_dsp_pkg;

    localparam int unsigned DEF_A_WIDTH     = 20;
    localparam int unsigned DEF_B_WIDTH     = 18;
    localparam int unsigned DEF_GUARD_BITS  = 6;
    localparam int unsigned DEF_Z_WIDTH     = 38;
    localparam int unsigned DEF_SHIFT_WIDTH = 6;

    // Widest value sat_clamp can handle; covers ACC_W+1 for any sane configuration.
    localparam int unsigned SAT_MAX_W = 128;

    function automatic int unsigned acc_width(input int unsigned a_w,
                                              input int unsigned b_w,
                                              input int unsigned guard);
        return a_w + b_w + guard;
    endfunction

    localparam int unsigned DEF_ACC_W = acc_width(DEF_A_WIDTH, DEF_B_WIDTH, DEF_GUARD_BITS);

    // Range bound nearest to an out-of-range value: the top bit of value gives its sign.
    function automatic logic [SAT_MAX_W-1:0] sat_clamp(input logic [SAT_MAX_W-1:0] value,
                                                       input int unsigned          width,
                                                       input logic                 is_signed);
        logic [SAT_MAX_W-1:0] one;
        logic [SAT_MAX_W-1:0] umax;
        one  = SAT_MAX_W'(1);
        umax = (one << width) - one;
        if (is_signed) begin
            sat_clamp = value[SAT_MAX_W-1] ? ~(umax >> 1) : (umax >> 1);
        end else begin
            sat_clamp = value[SAT_MAX_W-1] ? '0 : umax;
        end
    endfunction

endpackage

// File: rtl/rs_dsp_multacc_param_if.sv
// Sample and result bus of the multiply-accumulate datapath.
interface rs_dsp_multacc_param_if
    import rs_dsp_pkg::*;
#(
    parameter int unsigned A_WIDTH     = DEF_A_WIDTH,
    parameter int unsigned B_WIDTH     = DEF_B_WIDTH,
    parameter int unsigned Z_WIDTH     = DEF_Z_WIDTH,
    parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH
);
    logic                   in_valid;
    logic [A_WIDTH-1:0]     a;
    logic [B_WIDTH-1:0]     b;
    logic                   unsigned_a;
    logic                   unsigned_b;
    logic                   load_acc;
    logic                   subtract;
    logic                   saturate_enable;
    logic [SHIFT_WIDTH-1:0] shift_right;
    logic                   round;
    logic [Z_WIDTH-1:0]     z;
    logic [B_WIDTH-1:0]     dly_b;
    logic                   out_valid;
    logic                   overflow;

    modport master (
        output in_valid, a, b, unsigned_a, unsigned_b, load_acc, subtract,
               saturate_enable, shift_right, round,
        input  z, dly_b, out_valid, overflow
    );

    modport slave (
        input  in_valid, a, b, unsigned_a, unsigned_b, load_acc, subtract,
               saturate_enable, shift_right, round,
        output z, dly_b, out_valid, overflow
    );
endinterface

// File: rtl/rs_dsp_out_stage.sv
// Combinational output stage: round half-up, shift, range check and optional clamp.
module rs_dsp_out_stage
    import rs_dsp_pkg::*;
#(
    parameter int unsigned ACC_W       = DEF_ACC_W,
    parameter int unsigned Z_WIDTH     = DEF_Z_WIDTH,
    parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic [ACC_W-1:0]       acc,
    input  logic                   is_signed,
    input  logic                   round,
    input  logic                   saturate_enable,
    input  logic [SHIFT_WIDTH-1:0] shift_right,
    output logic [Z_WIDTH-1:0]     z,
    output logic                   overflow
);
    localparam int unsigned S_W = ACC_W + 1;

    logic [S_W-1:0] acc_ext;
    logic [S_W-1:0] rnd_add;
    logic [S_W-1:0] sum;
    logic [S_W-1:0] s;

    // One extra bit keeps the rounding increment from wrapping the accumulator value.
    always_comb begin
        acc_ext = {is_signed & acc[ACC_W-1], acc};
        rnd_add = '0;
        if (round && (shift_right != '0)) begin
            rnd_add = S_W'(1) << (shift_right - SHIFT_WIDTH'(1));
        end
        sum = acc_ext + rnd_add;
        if (is_signed) begin
            s = $signed(sum) >>> shift_right;
        end else begin
            s = sum >> shift_right;
        end
    end

    generate
        if (Z_WIDTH >= S_W) begin : g_wide
            logic unused_sat;
            assign unused_sat = saturate_enable;
            assign overflow   = 1'b0;
            // Result always fits: plain sign or zero extension.
            always_comb begin
                if (is_signed) begin
                    z = Z_WIDTH'($signed(s));
                end else begin
                    z = Z_WIDTH'(s);
                end
            end
        end else begin : g_narrow
            logic fits;
            // Range check on the discarded high bits, then clamp or wrap.
            always_comb begin
                if (is_signed) begin
                    fits = (s[S_W-1:Z_WIDTH-1] == '0) || (s[S_W-1:Z_WIDTH-1] == '1);
                end else begin
                    fits = (s[S_W-1:Z_WIDTH] == '0);
                end
                overflow = ~fits;
                z        = s[Z_WIDTH-1:0];
                if (!fits && saturate_enable) begin
                    if (is_signed) begin
                        z = Z_WIDTH'(sat_clamp(SAT_MAX_W'($signed(s)), Z_WIDTH, 1'b1));
                    end else begin
                        z = Z_WIDTH'(sat_clamp(SAT_MAX_W'(s), Z_WIDTH, 1'b0));
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rs_dsp_multacc_param.sv
// Parametrised multiply-accumulate with selectable input/output register stages.
module rs_dsp_multacc_param
    import rs_dsp_pkg::*;
#(
    parameter int unsigned A_WIDTH     = DEF_A_WIDTH,
    parameter int unsigned B_WIDTH     = DEF_B_WIDTH,
    parameter int unsigned GUARD_BITS  = DEF_GUARD_BITS,
    parameter int unsigned Z_WIDTH     = DEF_Z_WIDTH,
    parameter int unsigned SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int unsigned REG_IN      = 0,
    parameter int unsigned REG_OUT     = 1
) (
    input logic                  clk,
    input logic                  lreset,
    rs_dsp_multacc_param_if.slave bus
);
    localparam int unsigned ACC_W = acc_width(A_WIDTH, B_WIDTH, GUARD_BITS);

    logic                   s0_valid, s0_ua, s0_ub, s0_load, s0_sub, s0_sat, s0_round;
    logic [A_WIDTH-1:0]     s0_a;
    logic [B_WIDTH-1:0]     s0_b;
    logic [SHIFT_WIDTH-1:0] s0_shift;

    generate
        if (REG_IN != 0) begin : g_reg_in
            // Optional input register in front of the multiplier.
            always_ff @(posedge clk or negedge lreset) begin
                if (!lreset) begin
                    s0_valid <= 1'b0;
                    s0_a     <= '0;
                    s0_b     <= '0;
                    s0_ua    <= 1'b0;
                    s0_ub    <= 1'b0;
                    s0_load  <= 1'b0;
                    s0_sub   <= 1'b0;
                    s0_sat   <= 1'b0;
                    s0_shift <= '0;
                    s0_round <= 1'b0;
                end else begin
                    s0_valid <= bus.in_valid;
                    s0_a     <= bus.a;
                    s0_b     <= bus.b;
                    s0_ua    <= bus.unsigned_a;
                    s0_ub    <= bus.unsigned_b;
                    s0_load  <= bus.load_acc;
                    s0_sub   <= bus.subtract;
                    s0_sat   <= bus.saturate_enable;
                    s0_shift <= bus.shift_right;
                    s0_round <= bus.round;
                end
            end
        end else begin : g_no_reg_in
            // Bypass: the multiplier sees the bus directly.
            always_comb begin
                s0_valid = bus.in_valid;
                s0_a     = bus.a;
                s0_b     = bus.b;
                s0_ua    = bus.unsigned_a;
                s0_ub    = bus.unsigned_b;
                s0_load  = bus.load_acc;
                s0_sub   = bus.subtract;
                s0_sat   = bus.saturate_enable;
                s0_shift = bus.shift_right;
                s0_round = bus.round;
            end
        end
    endgenerate

    logic [ACC_W-1:0] a_ext, b_ext, prod, addend;

    // Each operand is extended per its own flag; the product wraps modulo 2^ACC_W.
    always_comb begin
        a_ext  = {{(ACC_W-A_WIDTH){s0_a[A_WIDTH-1] & ~s0_ua}}, s0_a};
        b_ext  = {{(ACC_W-B_WIDTH){s0_b[B_WIDTH-1] & ~s0_ub}}, s0_b};
        prod   = a_ext * b_ext;
        addend = s0_sub ? -prod : prod;
    end

    logic [ACC_W-1:0]       acc;
    logic [B_WIDTH-1:0]     dly_b_q;
    logic                   acc_valid, acc_signed, acc_sat, acc_round;
    logic [SHIFT_WIDTH-1:0] acc_shift;

    // Accumulator plus the output controls that travel with the sample; all hold on idle cycles.
    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            acc        <= '0;
            dly_b_q    <= '0;
            acc_valid  <= 1'b0;
            acc_signed <= 1'b0;
            acc_sat    <= 1'b0;
            acc_round  <= 1'b0;
            acc_shift  <= '0;
        end else begin
            acc_valid <= s0_valid;
            if (s0_valid) begin
                acc        <= (s0_load ? '0 : acc) + addend;
                dly_b_q    <= s0_b;
                acc_signed <= ~(s0_ua & s0_ub);
                acc_sat    <= s0_sat;
                acc_round  <= s0_round;
                acc_shift  <= s0_shift;
            end
        end
    end

    assign bus.dly_b = dly_b_q;

    logic [Z_WIDTH-1:0] oz;
    logic               oov;

    rs_dsp_out_stage #(
        .ACC_W       (ACC_W),
        .Z_WIDTH     (Z_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_out_stage (
        .acc             (acc),
        .is_signed       (acc_signed),
        .round           (acc_round),
        .saturate_enable (acc_sat),
        .shift_right     (acc_shift),
        .z               (oz),
        .overflow        (oov)
    );

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [Z_WIDTH-1:0] z_q;
            logic               ov_q, valid_q;
            // Output register; z and overflow update only with a valid sample.
            always_ff @(posedge clk or negedge lreset) begin
                if (!lreset) begin
                    z_q     <= '0;
                    ov_q    <= 1'b0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= acc_valid;
                    if (acc_valid) begin
                        z_q  <= oz;
                        ov_q <= oov;
                    end
                end
            end
            assign bus.z         = z_q;
            assign bus.overflow  = ov_q;
            assign bus.out_valid = valid_q;
        end else begin : g_no_reg_out
            assign bus.z         = oz;
            assign bus.overflow  = oov;
            assign bus.out_valid = acc_valid;
        end
    endgenerate

endmodule

// File: tb/tb_rs_dsp_multacc_param.sv
// Bench for rs_dsp_multacc_param: three configurations driven with the same stimulus
// and compared against an arithmetic reference model.
module tb_rs_dsp_multacc_param;

    localparam int NCFG  = 3;
    localparam int DEPTH = 1024;
    localparam int ACCW  = 44;

    logic        clk = 1'b0;
    logic        lreset;
    logic        in_valid, ua, ub, load_acc, subtract, sat_en, rnd;
    logic [19:0] a;
    logic [17:0] b;
    logic [5:0]  shr;

    always #5 clk = ~clk;

    rs_dsp_multacc_param_if #(.Z_WIDTH(38)) if_def ();
    rs_dsp_multacc_param_if #(.Z_WIDTH(16)) if_z16 ();
    rs_dsp_multacc_param_if #(.Z_WIDTH(38)) if_rio ();

    assign if_def.in_valid = in_valid;   assign if_z16.in_valid = in_valid;   assign if_rio.in_valid = in_valid;
    assign if_def.a = a;                 assign if_z16.a = a;                 assign if_rio.a = a;
    assign if_def.b = b;                 assign if_z16.b = b;                 assign if_rio.b = b;
    assign if_def.unsigned_a = ua;       assign if_z16.unsigned_a = ua;       assign if_rio.unsigned_a = ua;
    assign if_def.unsigned_b = ub;       assign if_z16.unsigned_b = ub;       assign if_rio.unsigned_b = ub;
    assign if_def.load_acc = load_acc;   assign if_z16.load_acc = load_acc;   assign if_rio.load_acc = load_acc;
    assign if_def.subtract = subtract;   assign if_z16.subtract = subtract;   assign if_rio.subtract = subtract;
    assign if_def.saturate_enable = sat_en; assign if_z16.saturate_enable = sat_en; assign if_rio.saturate_enable = sat_en;
    assign if_def.shift_right = shr;     assign if_z16.shift_right = shr;     assign if_rio.shift_right = shr;
    assign if_def.round = rnd;           assign if_z16.round = rnd;           assign if_rio.round = rnd;

    rs_dsp_multacc_param #(.Z_WIDTH(38)) u_def (.clk(clk), .lreset(lreset), .bus(if_def.slave));
    rs_dsp_multacc_param #(.Z_WIDTH(16)) u_z16 (.clk(clk), .lreset(lreset), .bus(if_z16.slave));
    rs_dsp_multacc_param #(.REG_IN(1), .REG_OUT(0)) u_rio (.clk(clk), .lreset(lreset), .bus(if_rio.slave));

    // Per-configuration output width and register stages.
    int    zw     [NCFG] = '{38, 16, 38};
    int    lat_in [NCFG] = '{0, 0, 1};
    int    lat_out[NCFG] = '{1, 1, 0};
    string cname  [NCFG] = '{"def", "z16", "rio"};

    // Expected timeline, indexed by configuration and clock edge number.
    bit          ev  [NCFG][DEPTH];
    longint      ez  [NCFG][DEPTH];
    bit          eov [NCFG][DEPTH];
    bit          dset[NCFG][DEPTH];
    logic [17:0] dval[NCFG][DEPTH];
    logic [17:0] cur_db[NCFG];

    longint m_acc;
    int     edge_cnt;
    int     n_vec;
    int     n_bad;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic get_outs(input int k, output logic [63:0] gz, output logic [63:0] gv,
                            output logic [63:0] gov, output logic [63:0] gdb);
        case (k)
            0: begin gz = 64'(if_def.z); gv = 64'(if_def.out_valid); gov = 64'(if_def.overflow); gdb = 64'(if_def.dly_b); end
            1: begin gz = 64'(if_z16.z); gv = 64'(if_z16.out_valid); gov = 64'(if_z16.overflow); gdb = 64'(if_z16.dly_b); end
            default: begin gz = 64'(if_rio.z); gv = 64'(if_rio.out_valid); gov = 64'(if_rio.overflow); gdb = 64'(if_rio.dly_b); end
        endcase
    endtask

    // Reference: signed or unsigned integer arithmetic on the accepted sample stream.
    task automatic model_accept(input int n);
        longint av, bv, p, v, s, lo, hi, zx, zmask, accmask;
        bit     sgn, ov;
        int     oe, de;
        accmask = (longint'(1) <<< ACCW) - 1;
        if (ua) av = longint'(a); else av = longint'(signed'(a));
        if (ub) bv = longint'(b); else bv = longint'(signed'(b));
        p = av * bv;
        if (subtract) p = -p;
        m_acc = ((load_acc ? 64'sd0 : m_acc) + p) & accmask;
        sgn = !(ua && ub);
        for (int k = 0; k < NCFG; k++) begin
            v = (sgn && m_acc[ACCW-1]) ? m_acc - (longint'(1) <<< ACCW) : m_acc;
            if (rnd && shr != 0) v = v + (longint'(1) <<< (shr - 1));
            s = v >>> shr;
            zmask = (longint'(1) <<< zw[k]) - 1;
            if (sgn) begin
                lo = -(longint'(1) <<< (zw[k] - 1));
                hi = (longint'(1) <<< (zw[k] - 1)) - 1;
            end else begin
                lo = 0;
                hi = zmask;
            end
            ov = (s < lo) || (s > hi);
            zx = (ov && sat_en) ? ((s < lo) ? lo : hi) : s;
            oe = n + lat_in[k] + lat_out[k];
            de = n + lat_in[k];
            if (oe < DEPTH) begin
                ev[k][oe]  = 1'b1;
                ez[k][oe]  = zx & zmask;
                eov[k][oe] = ov;
            end
            if (de < DEPTH) begin
                dset[k][de] = 1'b1;
                dval[k][de] = b;
            end
        end
    endtask

    task automatic check_all(input int m);
        logic [63:0] gz, gv, gov, gdb;
        for (int k = 0; k < NCFG; k++) begin
            if (m < DEPTH && dset[k][m]) cur_db[k] = dval[k][m];
            get_outs(k, gz, gv, gov, gdb);
            check_val($sformatf("%s.out_valid@%0d", cname[k], m), gv, 64'(ev[k][m]));
            if (ev[k][m]) begin
                check_val($sformatf("%s.z@%0d", cname[k], m), gz, ez[k][m]);
                check_val($sformatf("%s.overflow@%0d", cname[k], m), gov, 64'(eov[k][m]));
            end
            check_val($sformatf("%s.dly_b@%0d", cname[k], m), gdb, 64'(cur_db[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        check_all(edge_cnt);
    endtask

    task automatic apply(input bit v, input logic [19:0] ia, input logic [17:0] ib,
                         input bit iua, input bit iub, input bit ild, input bit isub,
                         input bit isat, input logic [5:0] ish, input bit ir);
        in_valid = v; a = ia; b = ib; ua = iua; ub = iub;
        load_acc = ild; subtract = isub; sat_en = isat; shr = ish; rnd = ir;
        if (v) model_accept(edge_cnt + 1);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Asserts reset between clock edges and checks the outputs clear without an edge.
    task automatic do_reset();
        logic [63:0] gz, gv, gov, gdb;
        in_valid = 1'b0;
        #2 lreset = 1'b0;
        #1;
        for (int k = 0; k < NCFG; k++) begin
            get_outs(k, gz, gv, gov, gdb);
            check_val($sformatf("%s.rst_z", cname[k]), gz, 64'd0);
            check_val($sformatf("%s.rst_out_valid", cname[k]), gv, 64'd0);
            check_val($sformatf("%s.rst_overflow", cname[k]), gov, 64'd0);
            check_val($sformatf("%s.rst_dly_b", cname[k]), gdb, 64'd0);
            cur_db[k] = '0;
            for (int m = edge_cnt + 1; m < DEPTH; m++) begin
                ev[k][m]   = 1'b0;
                dset[k][m] = 1'b0;
            end
        end
        m_acc = 0;
        #1 lreset = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; edge_cnt = 0; m_acc = 0;
        lreset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ua = 1'b0; ub = 1'b0;
        load_acc = 1'b0; subtract = 1'b0; sat_en = 1'b0; shr = '0; rnd = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            cur_db[k] = '0;
            for (int m = 0; m < DEPTH; m++) begin
                ev[k][m] = 1'b0; ez[k][m] = 0; eov[k][m] = 1'b0; dset[k][m] = 1'b0; dval[k][m] = '0;
            end
        end
        do_reset();

        // Signed MAC: 3*4 then -2*5.
        apply(1'b1, 20'd3, 18'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        apply(1'b1, 20'hFFFFE, 18'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        idle(3);

        // Reset mid-run discards the sum; next sample with load_acc=0 starts fresh.
        apply(1'b1, 20'd3, 18'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        idle(3);
        do_reset();
        apply(1'b1, 20'd2, 18'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        idle(3);

        // Subtract after a gap of idle cycles.
        apply(1'b1, 20'd10, 18'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        idle(3);
        apply(1'b1, 20'd1, 18'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
        idle(3);

        // Round and shift on +7 / -7.
        apply(1'b1, 20'd7, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 1'b1);
        apply(1'b1, 20'd7, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 1'b0);
        apply(1'b1, 20'hFFFF9, 18'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd1, 1'b1);
        idle(3);

        // Saturation and wrap at full-scale signed operands.
        apply(1'b1, 20'd524287, 18'd131071, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0);
        apply(1'b1, 20'd524287, 18'd131071, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        apply(1'b1, 20'h80000, 18'd131071, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0);
        idle(3);

        // Unsigned full scale.
        apply(1'b1, 20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            apply($urandom_range(0, 9) < 8, 20'($urandom), 18'($urandom),
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, 1'($urandom),
                  1'($urandom), 6'($urandom_range(0, 24)), 1'($urandom));
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_dsp_multacc_param.md
Name: rs_dsp_multacc_param

Overview:
- Parametrised, synthesisable multiply-accumulate datapath; successor to the fixed 20x18 MULTACC primitive family.
- Generalises operand, accumulator and output widths, and makes input/output register stages selectable by parameter.
- Adds a valid handshake, an overflow flag and a parameter-selected saturation range.
- Serves as the behavioural model and as the soft-logic fallback when hard DSP tiles are exhausted.

Parameters:
- A_WIDTH, 20, width of operand a.
- B_WIDTH, 18, width of operand b.
- GUARD_BITS, 6, accumulator headroom; ACC_W = A_WIDTH+B_WIDTH+GUARD_BITS.
- Z_WIDTH, 38, output width.
- SHIFT_WIDTH, 6, width of shift_right.
- REG_IN, 0, 1 = register a, b and all controls before the multiplier.
- REG_OUT, 1, 1 = register z, out_valid and overflow after the output stage.

Ports:
- clk  input  1  rising-edge clock.
- lreset  input  1  asynchronous active-low reset.
- in_valid  input  1  sample qualifier.
- a  input  A_WIDTH  multiplicand.
- b  input  B_WIDTH  multiplier.
- unsigned_a  input  1  1 = a is unsigned.
- unsigned_b  input  1  1 = b is unsigned.
- load_acc  input  1  1 = restart accumulation with this product.
- subtract  input  1  1 = negate the product before accumulating.
- saturate_enable  input  1  clamp z to the output range instead of wrapping.
- shift_right  input  SHIFT_WIDTH  arithmetic right shift applied at the output.
- round  input  1  round half-up before the shift.
- z  output  Z_WIDTH  result.
- dly_b  output  B_WIDTH  b of the last accepted sample.
- out_valid  output  1  z updated this cycle.
- overflow  output  1  shifted result did not fit in Z_WIDTH.

Behaviour:
- Reset: lreset low asynchronously clears acc, dly_b, all pipeline registers, z, out_valid and overflow to 0.
- Reset mid-accumulation discards the partial sum; the next accepted sample behaves as if load_acc=1.
- Signedness: the sample is signed if !(unsigned_a & unsigned_b). The signed flag travels with the sample through the pipeline.
- Product: P = a*b, each operand sign- or zero-extended according to its own flag, extended to ACC_W.
- Accumulator update on an accepted sample:
  - load_acc=1: acc <= subtract ? -P : P.
  - load_acc=0: acc <= acc ± P.
  - Arithmetic is modulo 2^ACC_W (wraps silently).
- in_valid=0 (after REG_IN): acc, dly_b and all registered controls hold; out_valid=0 at the matching output cycle.
- dly_b loads b on every accepted sample.
- Output stage, using shift_right/round/saturate_enable registered with the same sample:
  - s = (acc + (round && shift_right!=0 ? 2^(shift_right-1) : 0)) >>> shift_right, computed in ACC_W+1 bits.
  - Shift is arithmetic when signed, logical when unsigned.
  - Representable range: signed [-2^(Z-1), 2^(Z-1)-1]; unsigned [0, 2^Z-1].
  - If s is in range: z = s and overflow = 0.
  - If s is out of range: overflow = 1. With saturate_enable=1, z clamps to the nearer range bound; otherwise z = s[Z_WIDTH-1:0].
- If Z_WIDTH >= ACC_W+1: z is sign- or zero-extended from s and overflow is tied to 0.
- Latency from accepted input to out_valid = REG_IN + 1 + REG_OUT cycles. The defaults give 2.
- One sample per cycle; no backpressure.
- REG_OUT=0: z, overflow and out_valid are combinational from the acc register and its companion registers.

Decomposition:
- Package rs_dsp_pkg holds:
  - default width constants;
  - function sat_clamp(value, width, is_signed);
  - localparam ACC_W derivation.
- Sub-module rs_dsp_out_stage implements round + shift + range check + saturation.
  - It is purely combinational.
  - The parent wraps it with the REG_OUT register.

Test Plan:
- Reset mid-run: accumulate 3*4, then drive lreset low between clock edges -> z=0, out_valid=0 and overflow=0 immediately, without a clock edge. Next sample 2*2 with load_acc=0 -> z=4.
- Signed MAC, defaults: (load_acc=1, a=3, b=4), (a=-2, b=5) on consecutive cycles -> z=12 then z=2, each 2 cycles after its input. dly_b=4 then 5.
- Subtract with gaps: load 10*10, hold in_valid=0 for 3 cycles, then 1*1 with subtract=1 -> z=100, out_valid low for 3 cycles, then z=99. acc unchanged across the gap.
- Round/shift: acc=7, shift_right=1: round=1 -> z=4, round=0 -> z=3. acc=-7, shift_right=1, round=1 -> z=-3.
- Saturation, Z_WIDTH=16, signed: a=524287, b=131071.
  - saturate_enable=1 -> z=32767, overflow=1.
  - saturate_enable=0 -> z=16'h0001, overflow=1.
  - a=-524288, b=131071, saturate_enable=1 -> z=-32768.
- Unsigned full scale, defaults: unsigned_a=unsigned_b=1, a=20'hFFFFF, b=18'h3FFFF, load_acc=1 -> z=38'h3F_FFEC_0001, overflow=0. Repeat with REG_IN=1, REG_OUT=0 -> same value at latency 2.
